// File: rtl/sincronia_vga.sv
`default_nettype none
// ============================================================================
// Module      : sincronia_vga
// Description : Vertical line counter and registered VGA sync generator.
//               Samples the upstream horizontal count each pixel clock,
//               advances the line index at every line end and produces
//               hsync / vsync / video_on / pixel coordinates / frame_start,
//               all registered one cycle after the sampled hcuenta.
//               Optional macro FRAME_COUNT_EN adds an 8-bit frame counter
//               output (cuadro); without it the port and register are absent.
// Revision    : 1.0 - initial release
// ============================================================================
module sincronia_vga #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_LAST    = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_LAST    = 524
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [9:0] hcuenta,
    output logic [9:0] vcuenta,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
`ifdef FRAME_COUNT_EN
    ,
    output logic [7:0] cuadro
`endif
);

    // ------------------------------------------------------------------------
    // Timing boundaries, all reduced to the 10-bit compare domain
    // ------------------------------------------------------------------------
    localparam logic [9:0] c_H_VISIBLE  = 10'(H_VISIBLE);
    localparam logic [9:0] c_HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_H_LAST     = 10'(H_LAST);
    localparam logic [9:0] c_V_VISIBLE  = 10'(V_VISIBLE);
    localparam logic [9:0] c_VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_LAST);

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    logic [9:0] vcuenta_q,     vcuenta_d;
    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       video_on_q,    video_on_d;
    logic [9:0] pixel_x_q,     pixel_x_d;
    logic [9:0] pixel_y_q,     pixel_y_d;
    logic       frame_start_q, frame_start_d;

    // ------------------------------------------------------------------------
    // Combinational decode of the sampled horizontal count and the current
    // (pre-update) line index
    // ------------------------------------------------------------------------
    logic w_line_end;      // hcuenta sits on the last count of the line
    logic w_v_at_last;     // line index is at (or, unreachably, past) V_LAST
    logic w_h_in_sync;
    logic w_v_in_sync;
    logic w_h_visible;
    logic w_v_visible;
    logic w_visible;
    logic w_origin;

    assign w_line_end  = (hcuenta == c_H_LAST);
    // Treating anything past V_LAST as "last" lets a corrupted index recover
    // to 0 at the very next line end instead of counting up to 1023.
    assign w_v_at_last = (vcuenta_q >= c_V_LAST);

    assign w_h_in_sync = (hcuenta   >= c_HS_START) && (hcuenta   <= c_HS_END);
    assign w_v_in_sync = (vcuenta_q >= c_VS_START) && (vcuenta_q <= c_VS_END);
    assign w_h_visible = (hcuenta   <  c_H_VISIBLE);
    assign w_v_visible = (vcuenta_q <  c_V_VISIBLE);
    assign w_visible   = w_h_visible && w_v_visible;
    assign w_origin    = (hcuenta == 10'd0) && (vcuenta_q == 10'd0);

    // Next-state computation for the line counter and all decoded outputs
    always_comb begin
        vcuenta_d     = vcuenta_q;
        hsync_d       = 1'b1;
        vsync_d       = 1'b1;
        video_on_d    = 1'b0;
        pixel_x_d     = 10'd0;
        pixel_y_d     = 10'd0;
        frame_start_d = 1'b0;

        // Line index advances only on the line-end count; out-of-range
        // horizontal values never match and therefore simply hold it.
        if (w_line_end) begin
            if (w_v_at_last) begin
                vcuenta_d = 10'd0;
            end else begin
                vcuenta_d = vcuenta_q + 10'd1;
            end
        end

        // Sync pulses are active-low.
        hsync_d = ~w_h_in_sync;
        vsync_d = ~w_v_in_sync;

        // Coordinates are forced to zero outside the visible window so the
        // colour logic never sees blanking-region positions.
        video_on_d = w_visible;
        if (w_visible) begin
            pixel_x_d = hcuenta;
            pixel_y_d = vcuenta_q;
        end

        // First pixel of the frame; coincides with video_on first rising.
        frame_start_d = w_origin;
    end

    // Output and line-counter registers, cleared immediately by reset
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            vcuenta_q     <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            vcuenta_q     <= vcuenta_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vcuenta     = vcuenta_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;

`ifdef FRAME_COUNT_EN
    // ------------------------------------------------------------------------
    // Optional frame counter: bumps on the edge that wraps the line index
    // ------------------------------------------------------------------------
    logic [7:0] cuadro_q, cuadro_d;
    logic       w_frame_end;

    assign w_frame_end = w_line_end && w_v_at_last;

    // Free-running 8-bit frame count, naturally wrapping 255 -> 0
    always_comb begin
        cuadro_d = cuadro_q;
        if (w_frame_end) begin
            cuadro_d = cuadro_q + 8'd1;
        end
    end

    // Frame counter register, cleared immediately by reset
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            cuadro_q <= 8'd0;
        end else begin
            cuadro_q <= cuadro_d;
        end
    end

    assign cuadro = cuadro_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sincronia_vga.sv
`default_nettype none
// ============================================================================
// Module      : tb_sincronia_vga
// Description : Self-checking bench for sincronia_vga. Each driven hcuenta
//               pushes its expected registered outputs onto a scoreboard
//               queue; the entry is popped and compared one edge later.
//               Directed totals (sync widths, visible counts, frame pulses)
//               are checked per segment. Lines are skipped quickly by
//               driving hcuenta = 800 on consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sincronia_vga;

    logic       Clk = 1'b0;
    logic       reset;
    logic [9:0] hcuenta;
    logic [9:0] vcuenta;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
`ifdef FRAME_COUNT_EN
    logic [7:0] cuadro;
`endif

    sincronia_vga dut (
        .Clk         (Clk),
        .reset       (reset),
        .hcuenta     (hcuenta),
        .vcuenta     (vcuenta),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
`ifdef FRAME_COUNT_EN
        ,
        .cuadro      (cuadro)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vo;
        logic [9:0] px;
        logic [9:0] py;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int mv    = 0;     // model line index
    int cnt_hs, cnt_vs, cnt_vo, cnt_fs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        cnt_hs = 0; cnt_vs = 0; cnt_vo = 0; cnt_fs = 0;
    endtask

    // Drive one hcuenta value, predict, wait one edge, compare
    task automatic step(input int h);
        exp_t e;
        logic vis;
        hcuenta = 10'(h);
        vis  = (h < 640) && (mv < 480);
        e.hs = !((h >= 656) && (h <= 751));
        e.vs = !((mv >= 490) && (mv <= 491));
        e.vo = vis;
        e.px = vis ? 10'(h)  : 10'd0;
        e.py = vis ? 10'(mv) : 10'd0;
        e.fs = (h == 0) && (mv == 0);
        if (h == 800) mv = (mv >= 524) ? 0 : mv + 1;
        e.v  = 10'(mv);
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        check("vcuenta",     32'(vcuenta),     32'(e.v));
        check("hsync",       32'(hsync),       32'(e.hs));
        check("vsync",       32'(vsync),       32'(e.vs));
        check("video_on",    32'(video_on),    32'(e.vo));
        check("pixel_x",     32'(pixel_x),     32'(e.px));
        check("pixel_y",     32'(pixel_y),     32'(e.py));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        if (!hsync)      cnt_hs++;
        if (!vsync)      cnt_vs++;
        if (video_on)    cnt_vo++;
        if (frame_start) cnt_fs++;
    endtask

    task automatic full_line();
        for (int h = 0; h <= 800; h++) step(h);
    endtask

    task automatic skip_lines(input int n);
        for (int i = 0; i < n; i++) step(800);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vcuenta"},     32'(vcuenta),     32'd0);
        check({tag, "_hsync"},       32'(hsync),       32'd1);
        check({tag, "_vsync"},       32'(vsync),       32'd1);
        check({tag, "_video_on"},    32'(video_on),    32'd0);
        check({tag, "_pixel_x"},     32'(pixel_x),     32'd0);
        check({tag, "_pixel_y"},     32'(pixel_y),     32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        hcuenta = 10'd0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_values("por");

        // Release between edges; first edge then samples h with v = 0
        @(negedge Clk);
        reset = 1'b1;
        mv    = 0;

        // Line 0: sync width, visible width, single frame pulse
        clr_counts();
        full_line();
        check("line0_hsync_low_cycles",  32'(cnt_hs), 32'd96);
        check("line0_video_on_cycles",   32'(cnt_vo), 32'd640);
        check("line0_frame_start_count", 32'(cnt_fs), 32'd1);
        check("line0_vsync_low_cycles",  32'(cnt_vs), 32'd0);

        // Line 1 partially, then out-of-range input holds the line index
        for (int h = 0; h < 20; h++) step(h);
        for (int i = 0; i < 3; i++) step(900);
        check("oor_vcuenta",  32'(vcuenta),  32'd1);
        check("oor_hsync",    32'(hsync),    32'd1);
        check("oor_video_on", 32'(video_on), 32'd0);

        // Jump to line 489 and measure vsync around the pulse
        skip_lines(488);
        check("skip_to_489", 32'(vcuenta), 32'd489);
        clr_counts();
        full_line();
        check("line489_vsync_low", 32'(cnt_vs), 32'd0);
        clr_counts();
        full_line();
        full_line();
        check("line490_491_vsync_low", 32'(cnt_vs), 32'd1602);
        check("line490_491_video_on",  32'(cnt_vo), 32'd0);
        check("line490_491_hsync_low", 32'(cnt_hs), 32'd192);
        clr_counts();
        full_line();
        check("line492_vsync_low", 32'(cnt_vs), 32'd0);

        // Frame wrap at line 524 and the following frame pulse
        skip_lines(31);
        check("skip_to_524", 32'(vcuenta), 32'd524);
        clr_counts();
        step(800);
        check("wrap_vcuenta", 32'(vcuenta), 32'd0);
        step(0);
        step(1);
        step(2);
        check("wrap_frame_start_count", 32'(cnt_fs), 32'd1);

        // Mid-frame at line 300, then asynchronous reset between edges
        skip_lines(300);
        check("skip_to_300", 32'(vcuenta), 32'd300);
        step(10);
        check("l300_pixel_y",  32'(pixel_y),  32'd300);
        check("l300_video_on", 32'(video_on), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge Clk);
        #1;
        check_reset_values("held");
        @(negedge Clk);
        reset = 1'b1;
        mv    = 0;
        sb_q.delete();
        clr_counts();
        step(0);
        step(1);
        check("post_reset_frame_start_count", 32'(cnt_fs), 32'd1);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
